// File: rtl/plic_pkg.sv
// plic_pkg: register map offsets and sizing limits shared by the PLIC core files
package plic_pkg;
  localparam int MAX_IRQ = 31;
  localparam int MAX_TGT = 8;
  localparam logic [6:0] OFF_PRIO    = 7'h00;
  localparam logic [6:0] OFF_PENDING = 7'h20;
  localparam logic [6:0] OFF_EDGE    = 7'h21;
  localparam logic [6:0] OFF_ENABLE  = 7'h30;
  localparam logic [6:0] OFF_THRESH  = 7'h40;
  localparam logic [6:0] OFF_CLAIM   = 7'h50;
endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: per-source level/edge request gateway with inflight tracking and edge backlog
// Ports: clk_i/rst_i clock and async reset; irq_i source line; edge_i 1 = edge mode;
// mode_wr_i edge_mode register write; claim_i/complete_i qualified pulses;
// pending_o/inflight_o gateway state.
module plic_gateway import plic_pkg::*; #(
  parameter int EDGE_CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic edge_i,
  input  logic mode_wr_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic inflight_o
);
  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
  logic hist, rise, busy, dec, inc, set;
  logic [EDGE_CNT_W-1:0] cnt;
  // A completion that drains the backlog re-pends immediately; a rise that
  // coincides with it keeps the backlog level even when saturated.
  always_comb begin
    rise = edge_i & irq_i & ~hist;
    busy = pending_o | inflight_o;
    dec  = edge_i & complete_i & (cnt != '0);
    inc  = rise & busy & ((cnt != CNT_MAX) | dec);
    set  = edge_i ? (rise & ~busy) | dec : irq_i & ~inflight_o;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pending_o  <= 1'b0;
      inflight_o <= 1'b0;
      hist       <= 1'b0;
      cnt        <= '0;
    end else begin
      pending_o  <= ~claim_i & (pending_o | set);
      inflight_o <= claim_i | (inflight_o & ~complete_i);
      hist       <= ~mode_wr_i & irq_i;
      cnt        <= mode_wr_i ? '0 : cnt + EDGE_CNT_W'(inc) - EDGE_CNT_W'(dec);
    end
endmodule

// File: rtl/plic_core.sv
// plic_core: platform-level interrupt controller with per-target priority selection and claim/complete
// Ports: clk_i/rst_i clock and async reset; irq_i source lines (bit 0 ignored);
// reg_* single-cycle register access with combinational read data; irq_o per-target request.
module plic_core import plic_pkg::*; #(
  parameter int IRQ_NUM    = 31,
  parameter int PRIO_WIDTH = 3,
  parameter int TGT_NUM    = 2,
  parameter int EDGE_CNT_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM:0]   irq_i,
  input  logic               reg_valid_i,
  input  logic               reg_write_i,
  input  logic [6:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic [TGT_NUM-1:0] irq_o
);
  localparam int IW = $clog2(IRQ_NUM + 1);
  logic [PRIO_WIDTH-1:0] prio [IRQ_NUM:0];
  logic [IRQ_NUM:0] enable [TGT_NUM];
  logic [PRIO_WIDTH-1:0] threshold [TGT_NUM];
  logic [IW-1:0] best_id [TGT_NUM];
  logic [IRQ_NUM:0] pending, edge_mode;
  logic [IRQ_NUM:1] inflight, claim, complete;
  logic [IW-1:0] claim_id;
  logic wr, rd, edge_wr, cl_rd, cmp_wr, unused_irq0;
  assign wr          = reg_valid_i & reg_write_i;
  assign rd          = reg_valid_i & ~reg_write_i;
  assign edge_wr     = wr && reg_addr_i == OFF_EDGE;
  assign pending[0]  = 1'b0;
  assign unused_irq0 = irq_i[0];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i <= IRQ_NUM; i++) prio[i] <= '0;
      for (int t = 0; t < TGT_NUM; t++) begin
        enable[t]    <= '0;
        threshold[t] <= '0;
      end
      edge_mode <= '0;
    end else if (wr) begin
      for (int i = 1; i <= IRQ_NUM; i++)
        if (reg_addr_i == OFF_PRIO + 7'(i)) prio[i] <= reg_wdata_i[PRIO_WIDTH-1:0];
      for (int t = 0; t < TGT_NUM; t++) begin
        if (reg_addr_i == OFF_ENABLE + 7'(t)) enable[t] <= {reg_wdata_i[IRQ_NUM:1], 1'b0};
        if (reg_addr_i == OFF_THRESH + 7'(t)) threshold[t] <= reg_wdata_i[PRIO_WIDTH-1:0];
      end
      if (reg_addr_i == OFF_EDGE) edge_mode <= {reg_wdata_i[IRQ_NUM:1], 1'b0};
    end
  // A claim returns the target's registered winner only if it is still pending,
  // so a second target racing for the same source receives 0.
  always_comb begin
    claim_id = '0;
    cl_rd    = 1'b0;
    cmp_wr   = 1'b0;
    for (int t = 0; t < TGT_NUM; t++)
      if (reg_addr_i == OFF_CLAIM + 7'(t)) begin
        cl_rd    = rd;
        cmp_wr   = wr;
        claim_id = pending[best_id[t]] ? best_id[t] : '0;
      end
    for (int i = 1; i <= IRQ_NUM; i++) begin
      claim[i]    = cl_rd && claim_id == IW'(i);
      complete[i] = cmp_wr && reg_wdata_i == 32'(i) && inflight[i];
    end
  end
  always_comb begin
    reg_rdata_o = '0;
    if (rd) begin
      for (int i = 1; i <= IRQ_NUM; i++)
        if (reg_addr_i == OFF_PRIO + 7'(i)) reg_rdata_o = 32'(prio[i]);
      if (reg_addr_i == OFF_PENDING) reg_rdata_o = 32'(pending);
      if (reg_addr_i == OFF_EDGE) reg_rdata_o = 32'(edge_mode);
      for (int t = 0; t < TGT_NUM; t++) begin
        if (reg_addr_i == OFF_ENABLE + 7'(t)) reg_rdata_o = 32'(enable[t]);
        if (reg_addr_i == OFF_THRESH + 7'(t)) reg_rdata_o = 32'(threshold[t]);
        if (reg_addr_i == OFF_CLAIM + 7'(t)) reg_rdata_o = 32'(claim_id);
      end
    end
  end
  for (genvar i = 1; i <= IRQ_NUM; i++) begin : g_src
    plic_gateway #(.EDGE_CNT_W(EDGE_CNT_W)) u_gw (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .irq_i      (irq_i[i]),
      .edge_i     (edge_mode[i]),
      .mode_wr_i  (edge_wr),
      .claim_i    (claim[i]),
      .complete_i (complete[i]),
      .pending_o  (pending[i]),
      .inflight_o (inflight[i])
    );
  end
  for (genvar t = 0; t < TGT_NUM; t++) begin : g_tgt
    logic [IW-1:0] bid, bid_q;
    logic [PRIO_WIDTH-1:0] bp, bp_q;
    logic irq_q;
    // Strict greater-than keeps the lowest ID on ties and rejects priority 0.
    always_comb begin
      bid = '0;
      bp  = '0;
      for (int i = 1; i <= IRQ_NUM; i++)
        if (pending[i] && enable[t][i] && prio[i] > bp) begin
          bid = IW'(i);
          bp  = prio[i];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        bid_q <= '0;
        bp_q  <= '0;
        irq_q <= 1'b0;
      end else begin
        bid_q <= bid;
        bp_q  <= bp;
        irq_q <= bid_q != '0 && bp_q > threshold[t];
      end
    assign best_id[t] = bid_q;
    assign irq_o[t]   = irq_q;
  end
endmodule

// File: tb/tb_plic_core.sv
// tb_plic_core: directed self-checking bench for plic_core
module tb_plic_core;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] irq = '0;
  logic reg_valid = 1'b0, reg_write = 1'b0;
  logic [6:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic [1:0] irq_o;
  logic [31:0] d;
  int checks = 0, errors = 0;

  plic_core dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq), .reg_valid_i(reg_valid), .reg_write_i(reg_write),
    .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [6:0] a, input logic [31:0] v);
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = v;
    @(negedge clk);
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] v);
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a;
    #1 v = reg_rdata;
    @(negedge clk);
    reg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b expected 00", irq_o); end
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_idle: got %h expected 0", reg_rdata); end
    rd(7'h01, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_prio1: got %h expected 0", d); end
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
    rd(7'h30, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable0: got %h expected 0", d); end
    rd(7'h21, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_edge: got %h expected 0", d); end
  endtask

  task automatic test_regmap;
    wr(7'h01, 32'hFF); rd(7'h01, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL prio_trunc: got %h expected 7", d); end
    wr(7'h00, 32'h5); rd(7'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio0_ro: got %h expected 0", d); end
    wr(7'h30, 32'hFFFFFFFF); rd(7'h30, d); checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL enable_bit0: got %h expected fffffffe", d); end
    wr(7'h21, 32'hFFFFFFFF); rd(7'h21, d); checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL edge_bit0: got %h expected fffffffe", d); end
    wr(7'h20, 32'hFFFF); rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL pending_ro: got %h expected 0", d); end
    wr(7'h41, 32'h1F); rd(7'h41, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL thresh_trunc: got %h expected 7", d); end
    wr(7'h60, 32'h1); rd(7'h60, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_60: got %h expected 0", d); end
    wr(7'h32, 32'h1234); rd(7'h32, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_enable2: got %h expected 0", d); end
    wr(7'h01, 0); wr(7'h30, 0); wr(7'h21, 0); wr(7'h41, 0);
  endtask

  task automatic test_tie;
    wr(7'h03, 5); wr(7'h07, 5); wr(7'h30, 32'h88); wr(7'h40, 4);
    irq[3] = 1'b1; irq[7] = 1'b1;
    idle(2); checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL tie_irq_early: got %b expected 0", irq_o[0]); end
    idle(1); checks++; if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL tie_irq: got %b expected 1", irq_o[0]); end
    rd(7'h50, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL tie_claim: got %0d expected 3", d); end
    rd(7'h20, d); checks++; if (d !== 32'h80) begin errors++; $display("FAIL tie_pending: got %h expected 80", d); end
    rd(7'h50, d); checks++; if (d !== 32'd7) begin errors++; $display("FAIL tie_claim2: got %0d expected 7", d); end
    irq[3] = 1'b0; irq[7] = 1'b0;
    wr(7'h50, 3); wr(7'h50, 7); idle(3);
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL tie_irq_off: got %b expected 00", irq_o); end
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL tie_pending_off: got %h expected 0", d); end
    wr(7'h03, 0); wr(7'h07, 0); wr(7'h40, 0);
  endtask

  task automatic test_level;
    wr(7'h05, 1); wr(7'h30, 32'h20);
    irq[5] = 1'b1; idle(3);
    rd(7'h20, d); checks++; if (d !== 32'h20) begin errors++; $display("FAIL lvl_pending: got %h expected 20", d); end
    rd(7'h50, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL lvl_claim: got %0d expected 5", d); end
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lvl_inflight: got %h expected 0", d); end
    wr(7'h50, 5);
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lvl_cmpl_same: got %h expected 0", d); end
    rd(7'h20, d); checks++; if (d !== 32'h20) begin errors++; $display("FAIL lvl_repend: got %h expected 20", d); end
    irq[5] = 1'b0;
    rd(7'h50, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL lvl_claim2: got %0d expected 5", d); end
    wr(7'h50, 5); idle(1);
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL lvl_done: got %h expected 0", d); end
    wr(7'h05, 0);
  endtask

  task automatic test_edge;
    wr(7'h21, 32'h4); wr(7'h02, 2); wr(7'h30, 32'h4);
    irq[2] = 1'b1; idle(1); irq[2] = 1'b0; idle(3);
    rd(7'h50, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL edge_claim: got %0d expected 2", d); end
    for (int k = 0; k < 4; k++) begin
      irq[2] = 1'b1; idle(1); irq[2] = 1'b0; idle(1);
    end
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_backlog_pend: got %h expected 0", d); end
    for (int k = 0; k < 3; k++) begin
      wr(7'h50, 2);
      rd(7'h20, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL edge_repend%0d: got %h expected 4", k, d); end
      rd(7'h50, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL edge_reclaim%0d: got %0d expected 2", k, d); end
    end
    wr(7'h50, 2); idle(1);
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_drained: got %h expected 0", d); end
    wr(7'h21, 0); wr(7'h02, 0);
  endtask

  task automatic test_two_targets;
    wr(7'h04, 3); wr(7'h30, 32'h10); wr(7'h31, 32'h10); wr(7'h40, 0); wr(7'h41, 0);
    irq[4] = 1'b1; idle(3);
    checks++; if (irq_o !== 2'b11) begin errors++; $display("FAIL tgt_irq: got %b expected 11", irq_o); end
    rd(7'h50, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL tgt_claim0: got %0d expected 4", d); end
    rd(7'h51, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL tgt_claim1: got %0d expected 0", d); end
    idle(1); checks++; if (irq_o[1] !== 1'b0) begin errors++; $display("FAIL tgt_irq1_drop: got %b expected 0", irq_o[1]); end
  endtask

  task automatic test_errors;
    wr(7'h50, 0); wr(7'h50, 32); wr(7'h50, 3); wr(7'h51, 32'h104); idle(1);
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_complete: got %h expected 0", d); end
    wr(7'h51, 4); idle(1);
    rd(7'h20, d); checks++; if (d !== 32'h10) begin errors++; $display("FAIL good_complete: got %h expected 10", d); end
    wr(7'h40, 7); wr(7'h41, 7); wr(7'h04, 7); idle(3);
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL thresh_max: got %b expected 00", irq_o); end
    wr(7'h40, 6); idle(2);
    checks++; if (irq_o !== 2'b01) begin errors++; $display("FAIL thresh_6: got %b expected 01", irq_o); end
    wr(7'h04, 0); wr(7'h40, 0); wr(7'h41, 0); idle(3);
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL prio_zero: got %b expected 00", irq_o); end
    rd(7'h50, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_zero_claim: got %0d expected 0", d); end
    irq[4] = 1'b0;
  endtask

  task automatic test_reset_midclaim;
    wr(7'h06, 2); wr(7'h30, 32'h40); irq[6] = 1'b1; idle(3);
    rd(7'h50, d); checks++; if (d !== 32'd6) begin errors++; $display("FAIL rst_pre_claim: got %0d expected 6", d); end
    irq[6] = 1'b0; rst = 1'b1; idle(1); rst = 1'b0;
    checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL rst_irq: got %b expected 00", irq_o); end
    rd(7'h06, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio6: got %h expected 0", d); end
    rd(7'h20, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h expected 0", d); end
    rd(7'h30, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_enable: got %h expected 0", d); end
    idle(3); checks++; if (irq_o !== 2'b00) begin errors++; $display("FAIL rst_quiet: got %b expected 00", irq_o); end
    wr(7'h06, 2); wr(7'h30, 32'h40); irq[6] = 1'b1; idle(3);
    checks++; if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL rst_rereq_irq: got %b expected 1", irq_o[0]); end
    rd(7'h50, d); checks++; if (d !== 32'd6) begin errors++; $display("FAIL rst_rereq_claim: got %0d expected 6", d); end
    irq[6] = 1'b0; wr(7'h50, 6);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    test_reset;
    test_regmap;
    test_tie;
    test_level;
    test_edge;
    test_two_targets;
    test_errors;
    test_reset_midclaim;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
